map_scroll_sequencer: RTL and testbench
=======================================

// Module: map_scroll_sequencer
// PURPOSE
//   Sequences map-memory reads for the side-scrolling playfield. Per pixel from the
//   DTG: adds a per-frame horizontal scroll offset, forms the tile address for the
//   map memory, absorbs the memory read latency, and presents map_value,
//   out_of_map and world pixel coordinates, mutually aligned, to map_colorizer.
//   Owns the scroll-offset state machine, which advances once per frame.
// PARAMETERS
//   MAP_COLS     128  map width in tiles (power of 2)
//   MAP_ROWS     128  map height in tiles (power of 2)
//   TILE_SHIFT   3    log2 tile size in pixels (8x8 tiles)
//   MEM_LATENCY  1    map memory read latency in clocks (1..3)
//   SCREEN_W     640  visible width in pixels; used only when WRAP=0
//   WRAP         1    1: scroll wraps around the map; 0: scroll stops at the map end
// PORTS
//   clk            in   1   system clock
//   reset          in   1   synchronous reset, active-high
//   pixel_row      in   12  DTG pixel row
//   pixel_column   in   12  DTG pixel column
//   video_on       in   1   DTG visible-region flag
//   frame_tick     in   1   1-cycle pulse in vertical blanking, once per frame
//   scroll_enable  in   1   allows the scroll to advance on frame_tick
//   scroll_step    in   4   pixels added per frame
//   scroll_restart in   1   1-cycle pulse: return the scroll to 0
//   map_addr       out  14  map memory address = tile_row*MAP_COLS + tile_col
//   map_data       in   2   map memory data, MEM_LATENCY clocks after map_addr
//   map_value      out  2   map_data aligned with the outputs below
//   out_of_map     out  1   1 = pixel lies outside the map or outside video_on
//   world_row      out  12  delayed pixel_row
//   world_col      out  12  delayed pixel_column + scroll_x (wrapped when WRAP=1)
//   scroll_x       out  12  current scroll offset in world pixels
//   at_end         out  1   1 while in state END
// BEHAVIOUR
//   Reset values
//   - map_addr = 0, map_value = 0, out_of_map = 1, world_row = 0, world_col = 0.
//   - scroll_x = 0, at_end = 0, state = HOLD.
//   - All pipeline registers are cleared, and the out_of_map stages are set to 1.
//   Definitions
//   - MAP_W = MAP_COLS << TILE_SHIFT (1024 at the defaults).
//   - wc = pixel_column + scroll_x, computed at 13 bits.
//   - If WRAP=1, wc is taken mod MAP_W; if WRAP=0, it is not reduced.
//   Stage 0 (registered, 1 clk)
//   - tile_col = wc >> TILE_SHIFT; tile_row = pixel_row >> TILE_SHIFT.
//   - oom = !video_on | (tile_row >= MAP_ROWS) | (WRAP==0 & tile_col >= MAP_COLS).
//   - map_addr <= oom ? 0 : {tile_row, tile_col}.
//   - oom, pixel_row and wc[11:0] are registered alongside map_addr.
//   Delay stages
//   - oom, row and col pass through MEM_LATENCY further registers.
//   - map_value <= map_data, captured at the final stage.
//   - Total latency from pixel inputs to outputs = 1 + MEM_LATENCY clocks.
//   - The pipeline is free-running: one pixel per clock, no stalls.
//   Scroll FSM (evaluated on each clk edge)
//   - HOLD:   on frame_tick -> SCROLL. scroll_x does not change on this tick.
//   - SCROLL: on frame_tick & scroll_enable, nxt = scroll_x + scroll_step.
//       WRAP=1: scroll_x <= nxt mod MAP_W.
//       WRAP=0, nxt >= MAP_W-SCREEN_W: scroll_x <= MAP_W-SCREEN_W and -> END.
//       WRAP=0, otherwise: scroll_x <= nxt.
//   - END:    scroll_x holds and at_end = 1. Only scroll_restart leaves END.
//   - scroll_restart in any state: scroll_x <= 0, -> HOLD, at_end <= 0.
//   - scroll_restart has priority over a simultaneous frame_tick.
//   - scroll_step = 0: the FSM stays in SCROLL with no change to scroll_x.
//   - scroll_x changes only on frame_tick or restart, so it is constant for the
//     whole visible frame (no tearing).
//   - Reset asserted mid-frame clears the pipeline and the FSM on the next edge.
//     Outputs read out_of_map = 1 until valid pixels have refilled the pipeline.
// TESTING
//   1. Reset, MEM_LATENCY=1, row=17, col=9, video_on=1, scroll_x=0:
//      map_addr = 2*128+1 = 257 after 1 clk; world_col = 9 and out_of_map = 0 after 2 clks.
//   2. video_on=0, or row=1100 (tile_row 137 >= 128):
//      out_of_map = 1 and map_addr = 0.
//   3. HOLD, then frame_tick, then 3 frame_ticks with step=5 and enable=1:
//      scroll_x = 0, 5, 10, 15. With col=0, world_col = 15.
//   4. WRAP=1, scroll_x=1020, step=8, one frame_tick -> scroll_x = 4.
//      col=1023 -> world_col = 3, tile_col = 0.
//   5. WRAP=0, scroll_x=380, step=8, frame_tick -> scroll_x = 384 and at_end = 1.
//      Further ticks: no change.
//   6. frame_tick and scroll_restart in the same cycle in SCROLL:
//      scroll_x = 0, state HOLD. Repeat the bench with MEM_LATENCY=3 -> output latency 4.

Source files
------------

// File: rtl/map_scroll_sequencer.sv
// Map-memory read sequencer for the side-scrolling playfield: scroll-offset FSM plus
// a free-running pixel pipeline that aligns map data with world coordinates.
module map_scroll_sequencer #(
    parameter int MAP_COLS    = 128,
    parameter int MAP_ROWS    = 128,
    parameter int TILE_SHIFT  = 3,
    parameter int MEM_LATENCY = 1,
    parameter int SCREEN_W    = 640,
    parameter int WRAP        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        scroll_enable,
    input  logic [3:0]  scroll_step,
    input  logic        scroll_restart,
    output logic [13:0] map_addr,
    input  logic [1:0]  map_data,
    output logic [1:0]  map_value,
    output logic        out_of_map,
    output logic [11:0] world_row,
    output logic [11:0] world_col,
    output logic [11:0] scroll_x,
    output logic        at_end
);

    localparam int COL_BITS = $clog2(MAP_COLS);
    localparam int ROW_BITS = $clog2(MAP_ROWS);
    localparam int MAP_W    = MAP_COLS << TILE_SHIFT;

    localparam logic [12:0] MAP_W_MASK = 13'(MAP_W - 1);
    localparam logic [12:0] END_X      = 13'(MAP_W - SCREEN_W);
    localparam logic [12:0] COLS_LIM   = 13'(MAP_COLS);
    localparam logic [11:0] ROWS_LIM   = 12'(MAP_ROWS);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_SCROLL,
        ST_END
    } state_t;

    state_t state;

    logic [12:0]                  wc_sum;
    logic [12:0]                  wc;
    logic [12:0]                  tile_col;
    logic [11:0]                  tile_row;
    logic                         oom;
    logic [ROW_BITS+COL_BITS-1:0] addr_full;
    logic [12:0]                  next_x;

    // Index 0 is the address stage; index MEM_LATENCY drives the outputs.
    logic        oom_q [MEM_LATENCY+1];
    logic [11:0] row_q [MEM_LATENCY+1];
    logic [11:0] col_q [MEM_LATENCY+1];

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        wc_sum    = {1'b0, pixel_column} + {1'b0, scroll_x};
        wc        = (WRAP != 0) ? (wc_sum & MAP_W_MASK) : wc_sum;
        tile_col  = wc >> TILE_SHIFT;
        tile_row  = pixel_row >> TILE_SHIFT;
        oom       = !video_on || (tile_row >= ROWS_LIM) ||
                    ((WRAP == 0) && (tile_col >= COLS_LIM));
        addr_full = {tile_row[ROW_BITS-1:0], tile_col[COL_BITS-1:0]};
        next_x    = {1'b0, scroll_x} + {9'd0, scroll_step};
    end

    // NOTE: the delay line is a handful of flops, not a RAM, so it is reset in full;
    // out_of_map must read 1 until real pixels have refilled it.
    always_ff @(posedge clk) begin
        if (reset) begin
            map_addr  <= '0;
            map_value <= '0;
            for (int i = 0; i <= MEM_LATENCY; i++) begin
                oom_q[i] <= 1'b1;
                row_q[i] <= '0;
                col_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage read the previous stage's old value.
            map_addr  <= oom ? '0 : 14'(addr_full);
            oom_q[0]  <= oom;
            row_q[0]  <= pixel_row;
            col_q[0]  <= wc[11:0];
            for (int i = 1; i <= MEM_LATENCY; i++) begin
                oom_q[i] <= oom_q[i-1];
                row_q[i] <= row_q[i-1];
                col_q[i] <= col_q[i-1];
            end
            map_value <= map_data;
        end
    end

    assign out_of_map = oom_q[MEM_LATENCY];
    assign world_row  = row_q[MEM_LATENCY];
    assign world_col  = col_q[MEM_LATENCY];

    // scroll_x only moves on frame_tick (in blanking) or restart, so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset || scroll_restart) begin
            state    <= ST_HOLD;
            scroll_x <= '0;
            at_end   <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (frame_tick) state <= ST_SCROLL;
                end
                ST_SCROLL: begin
                    if (frame_tick && scroll_enable) begin
                        if (WRAP != 0) begin
                            scroll_x <= next_x[11:0] & MAP_W_MASK[11:0];
                        end else if (next_x >= END_X) begin
                            scroll_x <= END_X[11:0];
                            state    <= ST_END;
                            at_end   <= 1'b1;
                        end else begin
                            scroll_x <= next_x[11:0];
                        end
                    end
                end
                ST_END: begin
                    at_end <= 1'b1;
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_scroll_sequencer.sv
// Scoreboard bench: a wrapping MEM_LATENCY=1 instance and a clamping MEM_LATENCY=3
// instance share stimulus; directed pixels carry hand-computed expectations per instance.
module tb_map_scroll_sequencer;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pixel_row, pixel_column;
    logic        video_on, frame_tick, scroll_enable, scroll_restart;
    logic [3:0]  scroll_step;

    logic [13:0] addr_a, addr_b;
    logic [1:0]  data_a, data_b, value_a, value_b;
    logic        oom_a, oom_b, end_a, end_b;
    logic [11:0] wrow_a, wrow_b, wcol_a, wcol_b, sx_a, sx_b;

    always #5 clk = ~clk;

    map_scroll_sequencer #(.MEM_LATENCY(LAT_A), .WRAP(1)) dut_a (
        .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .frame_tick(frame_tick), .scroll_enable(scroll_enable),
        .scroll_step(scroll_step), .scroll_restart(scroll_restart), .map_addr(addr_a),
        .map_data(data_a), .map_value(value_a), .out_of_map(oom_a), .world_row(wrow_a),
        .world_col(wcol_a), .scroll_x(sx_a), .at_end(end_a)
    );

    map_scroll_sequencer #(.MEM_LATENCY(LAT_B), .WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .video_on(video_on), .frame_tick(frame_tick), .scroll_enable(scroll_enable),
        .scroll_step(scroll_step), .scroll_restart(scroll_restart), .map_addr(addr_b),
        .map_data(data_b), .map_value(value_b), .out_of_map(oom_b), .world_row(wrow_b),
        .world_col(wcol_b), .scroll_x(sx_b), .at_end(end_b)
    );

    // Map contents are a fixed function of the address; the map_addr register
    // counts as the first of the MEM_LATENCY clocks.
    function automatic logic [1:0] mem_f(input logic [13:0] a);
        return a[1:0] ^ a[8:7];
    endfunction

    logic [1:0] b_d1, b_d2;
    assign data_a = mem_f(addr_a);
    always @(posedge clk) begin
        b_d1 <= mem_f(addr_b);
        b_d2 <= b_d1;
    end
    assign data_b = b_d2;

    typedef struct {
        int          due;
        logic [13:0] addr;
        logic        oom;
        logic [11:0] row;
        logic [11:0] col;
    } exp_t;

    exp_t qa_addr[$], qa_out[$], qb_addr[$], qb_out[$];
    exp_t ea, eb;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop whenever an expected output is due this cycle.
    always @(negedge clk) begin
        if (qa_addr.size() > 0 && qa_addr[0].due == cyc) begin
            ea = qa_addr.pop_front();
            check("a_map_addr", 32'(addr_a), 32'(ea.addr));
        end
        if (qa_out.size() > 0 && qa_out[0].due == cyc) begin
            ea = qa_out.pop_front();
            check("a_out_of_map", 32'(oom_a), 32'(ea.oom));
            check("a_world_row", 32'(wrow_a), 32'(ea.row));
            check("a_world_col", 32'(wcol_a), 32'(ea.col));
            check("a_map_value", 32'(value_a), 32'(mem_f(ea.addr)));
        end
    end

    always @(negedge clk) begin
        if (qb_addr.size() > 0 && qb_addr[0].due == cyc) begin
            eb = qb_addr.pop_front();
            check("b_map_addr", 32'(addr_b), 32'(eb.addr));
        end
        if (qb_out.size() > 0 && qb_out[0].due == cyc) begin
            eb = qb_out.pop_front();
            check("b_out_of_map", 32'(oom_b), 32'(eb.oom));
            check("b_world_row", 32'(wrow_b), 32'(eb.row));
            check("b_world_col", 32'(wcol_b), 32'(eb.col));
            check("b_map_value", 32'(value_b), 32'(mem_f(eb.addr)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        video_on = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_pix(input logic [11:0] row, input logic [11:0] col, input logic von,
                            input logic [13:0] a_addr, input logic a_oom, input logic [11:0] a_col,
                            input logic [13:0] b_addr, input logic b_oom, input logic [11:0] b_col);
        pixel_row    = row;
        pixel_column = col;
        video_on     = von;
        qa_addr.push_back('{cyc + 1, a_addr, a_oom, row, a_col});
        qa_out.push_back('{cyc + 1 + LAT_A, a_addr, a_oom, row, a_col});
        qb_addr.push_back('{cyc + 1, b_addr, b_oom, row, b_col});
        qb_out.push_back('{cyc + 1 + LAT_B, b_addr, b_oom, row, b_col});
        step();
    endtask

    task automatic tick(input logic en, input logic [3:0] stp);
        scroll_enable = en;
        scroll_step   = stp;
        frame_tick    = 1'b1;
        step();
        frame_tick    = 1'b0;
    endtask

    task automatic check_scroll(input string name, input int a_x, input int b_x, input logic b_end);
        check({name, "_a_scroll_x"}, 32'(sx_a), 32'(a_x));
        check({name, "_b_scroll_x"}, 32'(sx_b), 32'(b_x));
        check({name, "_a_at_end"}, 32'(end_a), 32'd0);
        check({name, "_b_at_end"}, 32'(end_b), 32'(b_end));
    endtask

    initial begin
        reset = 1'b1;
        pixel_row = '0; pixel_column = '0; video_on = 1'b0;
        frame_tick = 1'b0; scroll_enable = 1'b0; scroll_step = '0; scroll_restart = 1'b0;
        step();
        step();
        check("rst_a_map_addr", 32'(addr_a), 0);
        check("rst_a_map_value", 32'(value_a), 0);
        check("rst_a_out_of_map", 32'(oom_a), 1);
        check("rst_a_world_row", 32'(wrow_a), 0);
        check("rst_a_world_col", 32'(wcol_a), 0);
        check("rst_b_map_addr", 32'(addr_b), 0);
        check("rst_b_out_of_map", 32'(oom_b), 1);
        check("rst_b_world_col", 32'(wcol_b), 0);
        check_scroll("rst", 0, 0, 1'b0);
        reset = 1'b0;

        // scroll 0 on both: basic address, blanking, row overflow, far map corner
        send_pix(12'd17,   12'd9,    1'b1, 14'd257,   1'b0, 12'd9,    14'd257,   1'b0, 12'd9);
        send_pix(12'd17,   12'd9,    1'b0, 14'd0,     1'b1, 12'd9,    14'd0,     1'b1, 12'd9);
        send_pix(12'd1100, 12'd9,    1'b1, 14'd0,     1'b1, 12'd9,    14'd0,     1'b1, 12'd9);
        send_pix(12'd1023, 12'd1023, 1'b1, 14'd16383, 1'b0, 12'd1023, 14'd16383, 1'b0, 12'd1023);
        idle(6);

        tick(1'b1, 4'd5);
        check_scroll("hold_first_tick", 0, 0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick(1'b1, 4'd5);
            check_scroll("step5", 5 * i, 5 * i, 1'b0);
        end

        send_pix(12'd0, 12'd0, 1'b1, 14'd1, 1'b0, 12'd15, 14'd1, 1'b0, 12'd15);
        idle(6);

        repeat (24) tick(1'b1, 4'd15);
        tick(1'b1, 4'd5);
        check_scroll("reach_380", 380, 380, 1'b0);
        tick(1'b1, 4'd8);
        check_scroll("clamp_384", 388, 384, 1'b1);

        // A: scroll 388 (wraps), B: scroll 384 (last valid column 639 -> 1023)
        send_pix(12'd8, 12'd639, 1'b1, 14'd128, 1'b0, 12'd3, 14'd255, 1'b0, 12'd1023);
        send_pix(12'd8, 12'd640, 1'b1, 14'd128, 1'b0, 12'd4, 14'd0,   1'b1, 12'd1024);
        idle(6);

        tick(1'b1, 4'd8);
        check_scroll("end_holds", 396, 384, 1'b1);
        repeat (41) tick(1'b1, 4'd15);
        tick(1'b1, 4'd9);
        check_scroll("reach_1020", 1020, 384, 1'b1);
        tick(1'b1, 4'd8);
        check_scroll("wrap_to_4", 4, 384, 1'b1);

        send_pix(12'd16, 12'd1023, 1'b1, 14'd256, 1'b0, 12'd3, 14'd0,   1'b1, 12'd1407);
        send_pix(12'd16, 12'd0,    1'b1, 14'd256, 1'b0, 12'd4, 14'd304, 1'b0, 12'd384);
        idle(6);

        tick(1'b1, 4'd0);
        check_scroll("step_zero", 4, 384, 1'b1);
        tick(1'b0, 4'd8);
        check_scroll("disabled", 4, 384, 1'b1);

        // restart wins over a simultaneous frame_tick and returns to HOLD
        scroll_restart = 1'b1;
        tick(1'b1, 4'd8);
        scroll_restart = 1'b0;
        check_scroll("restart", 0, 0, 1'b0);
        tick(1'b1, 4'd5);
        check_scroll("restart_hold", 0, 0, 1'b0);
        tick(1'b1, 4'd5);
        check_scroll("after_restart", 5, 5, 1'b0);

        // reset mid-frame with valid pixels in flight
        pixel_row = 12'd17; pixel_column = 12'd9; video_on = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        video_on = 1'b0;
        check("midrst_a_out_of_map", 32'(oom_a), 1);
        check("midrst_a_map_addr", 32'(addr_a), 0);
        check("midrst_b_out_of_map", 32'(oom_b), 1);
        check("midrst_b_map_addr", 32'(addr_b), 0);
        check_scroll("midrst", 0, 0, 1'b0);

        idle(4);
        check("drain_a", 32'(qa_addr.size() + qa_out.size()), 0);
        check("drain_b", 32'(qb_addr.size() + qb_out.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
